// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolution end of the fetch-side branch prediction path. Every prediction
// made at fetch (pc, direction, target) is queued in order. When the control
// instruction resolves in EX/MEM, the oldest queued prediction is compared
// against the actual outcome. A mispredict squashes the queue, raises flush
// for FLUSH_CYCLES cycles and issues a one-cycle redirect to the correct next
// pc. Every accepted resolve also strobes the predictor update port.
//
// Parameters
//   DEPTH        in-flight prediction entries (power of 2, >= 2)
//   PC_W         program counter width (>= 8)
//   FLUSH_CYCLES cycles flush stays high after a mispredict (>= 1)
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   push_valid/ready/pc/taken/target
//                                 prediction from the fetch controller
//   resolve_valid/pc/taken/target actual outcome from EX/MEM
//   flush                         squash younger instructions in IF/ID/EX
//   redirect_valid, redirect_pc   one-cycle pulse carrying the correct next pc
//   upd_valid, upd_pc, upd_taken  predictor update (index = resolve_pc[7:0])
//   q_count                       queue occupancy
//   err_sticky                    protocol error seen (empty queue or pc
//                                 mismatch on resolve); cleared only by rst
//
// Configuration
//   BRU_STATS_EN  when defined, adds stat_branches / stat_mispredicts:
//                 saturating counts of accepted resolves and mispredicts.
//
// Registered outputs appear one cycle after the resolve that caused them.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_taken,
  input  logic [PC_W-1:0]          push_target,
  input  logic                     resolve_valid,
  input  logic [PC_W-1:0]          resolve_pc,
  input  logic                     resolve_taken,
  input  logic [PC_W-1:0]          resolve_target,
  output logic                     flush,
  output logic                     redirect_valid,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [7:0]               upd_pc,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err_sticky
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t            state, state_nxt;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;

  // Prediction storage, split per field.
  logic [PC_W-1:0]   q_pc     [DEPTH];
  logic              q_taken  [DEPTH];
  logic [PC_W-1:0]   q_target [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic              q_empty;
  logic              push_acc;
  logic              resolve_acc;
  logic              pc_err;
  logic              mispredict;
  logic              pop;

  // ---------------------------------------------------------------------------
  // Handshake and compare against the queue head (all combinational).
  // ---------------------------------------------------------------------------
  // push_ready depends only on registered state, so a pop in the same cycle
  // does not open a slot for a push into a full queue.
  assign push_ready  = (state == ST_RUN) && (q_count != CNT_W'(DEPTH));
  assign flush       = (state == ST_FLUSH);
  assign q_empty     = (q_count == '0);
  assign push_acc    = push_valid && push_ready;
  assign resolve_acc = resolve_valid && (state == ST_RUN);

  assign pc_err      = resolve_acc && (q_empty || (q_pc[rd_ptr] != resolve_pc));
  assign mispredict  = resolve_acc &&
                       (q_empty
                        || (q_pc[rd_ptr]    != resolve_pc)
                        || (q_taken[rd_ptr] != resolve_taken)
                        || (resolve_taken && (q_target[rd_ptr] != resolve_target)));
  // A hit retires the head; a mispredict clears the whole queue instead.
  assign pop         = resolve_acc && !mispredict;

  // ---------------------------------------------------------------------------
  // FSM: RUN / FLUSH with a down-counter holding flush for FLUSH_CYCLES.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_RUN: begin
        if (mispredict) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FC_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FC_W'(1)) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt - FC_W'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue pointers and occupancy. Pointers wrap naturally (DEPTH is 2^n).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      // A mispredict squashes all younger predictions, including any push
      // offered in the same cycle.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_acc && !pop)      q_count <= q_count + CNT_W'(1);
      else if (pop && !push_acc) q_count <= q_count - CNT_W'(1);
    end
  end

  // NOTE: the entry storage is deliberately not reset; validity is tracked by
  // the pointers and count alone, so clearing the array would only cost reset
  // fan-out.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      q_pc[wr_ptr]     <= push_pc;
      q_taken[wr_ptr]  <= push_taken;
      q_target[wr_ptr] <= push_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered update / redirect / error outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      err_sticky     <= 1'b0;
    end else begin
      upd_valid      <= resolve_acc;
      redirect_valid <= mispredict;
      if (resolve_acc) begin
        upd_pc    <= resolve_pc[7:0];
        upd_taken <= resolve_taken;
      end
      if (mispredict) begin
        // Not-taken fall-through wraps modulo 2^PC_W.
        redirect_pc <= resolve_taken ? resolve_target : resolve_pc + PC_W'(4);
      end
      if (pc_err) err_sticky <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve_acc && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit (default build). A behavioural
// model (a queue of predictions plus a flush cycle budget) predicts every
// output; directed scenarios are followed by randomized push/resolve traffic
// with occasional resets.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int DEPTH        = 4;
  localparam int PC_W         = 32;
  localparam int FLUSH_CYCLES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              push_valid;
  logic              push_ready;
  logic [PC_W-1:0]   push_pc;
  logic              push_taken;
  logic [PC_W-1:0]   push_target;
  logic              resolve_valid;
  logic [PC_W-1:0]   resolve_pc;
  logic              resolve_taken;
  logic [PC_W-1:0]   resolve_target;
  logic              flush;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              upd_valid;
  logic [7:0]        upd_pc;
  logic              upd_taken;
  logic [$clog2(DEPTH):0] q_count;
  logic              err_sticky;

  branch_resolve_unit #(
    .DEPTH        (DEPTH),
    .PC_W         (PC_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_pc        (push_pc),
    .push_taken     (push_taken),
    .push_target    (push_target),
    .resolve_valid  (resolve_valid),
    .resolve_pc     (resolve_pc),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .q_count        (q_count),
    .err_sticky     (err_sticky)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  pred_t mq[$];          // in-flight predictions, oldest first
  int    m_flush_left;   // remaining flush cycles; 0 means running
  bit    m_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called right after a falling edge: check the state-derived outputs,
  // apply one cycle of stimulus, step the model, then check the registered
  // results just after the rising edge. Returns after the next falling edge.
  task automatic cycle(input bit pv, input logic [31:0] ppc, input bit pt,
                       input logic [31:0] ptgt, input bit rv, input logic [31:0] rpc,
                       input bit rt, input logic [31:0] rtgt);
    bit    running, ready, racc, empty, mis, perr;
    pred_t h;
    logic [31:0] exp_rpc;

    running = (m_flush_left == 0);
    ready   = running && (mq.size() < DEPTH);
    check("push_ready", 32'(push_ready), 32'(ready));
    check("q_count",    32'(q_count),    32'(mq.size()));
    check("err_sticky", 32'(err_sticky), 32'(m_err));

    push_valid = pv; push_pc = ppc; push_taken = pt; push_target = ptgt;
    resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt; resolve_target = rtgt;

    racc  = rv && running;
    empty = (mq.size() == 0);
    h     = '{pc: 32'h0, taken: 1'b0, target: 32'h0};
    if (!empty) h = mq[0];
    mis   = racc && (empty || h.pc != rpc || h.taken != rt || (rt && h.target != rtgt));
    perr  = racc && (empty || h.pc != rpc);
    exp_rpc = rt ? rtgt : rpc + 32'd4;

    if (mis) mq.delete();
    else begin
      if (racc) void'(mq.pop_front());
      if (pv && ready) mq.push_back('{pc: ppc, taken: pt, target: ptgt});
    end
    if (perr) m_err = 1'b1;
    if (m_flush_left > 0) m_flush_left--;
    else if (mis) m_flush_left = FLUSH_CYCLES;

    @(posedge clk);
    #1;
    check("upd_valid",      32'(upd_valid),      32'(racc));
    if (racc) begin
      check("upd_pc",    32'(upd_pc),    {24'h0, rpc[7:0]});
      check("upd_taken", 32'(upd_taken), 32'(rt));
    end
    check("redirect_valid", 32'(redirect_valid), 32'(mis));
    if (mis) check("redirect_pc", redirect_pc, exp_rpc);
    check("flush", 32'(flush), 32'(m_flush_left > 0));
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset for one edge from a falling edge; outputs must be at reset values
  // right after it regardless of what was in flight.
  task automatic do_reset();
    rst = 1'b1;
    push_valid = 1'b0; resolve_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_flush",          32'(flush),          32'd0);
    check("rst_push_ready",     32'(push_ready),     32'd1);
    check("rst_q_count",        32'(q_count),        32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_upd_valid",      32'(upd_valid),      32'd0);
    check("rst_err_sticky",     32'(err_sticky),     32'd0);
    mq.delete();
    m_flush_left = 0;
    m_err        = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ppc, ptgt, rpc, rtgt;
    bit          pv, pt, rv, rt;

    rst = 1'b1;
    push_valid = 0; push_pc = 0; push_taken = 0; push_target = 0;
    resolve_valid = 0; resolve_pc = 0; resolve_taken = 0; resolve_target = 0;
    m_flush_left = 0; m_err = 0;
    @(negedge clk);
    do_reset();

    // Correct prediction: update only, no flush.
    cycle(1, 32'h40, 1, 32'h80, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h40, 1, 32'h80);
    idle();

    // Predicted not-taken, actually taken -> redirect to 0x60, flush 2 cycles.
    cycle(1, 32'h40, 0, 32'h0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h40, 1, 32'h60);
    repeat (3) idle();

    // Predicted taken, actually not-taken -> redirect to 0x14, no error.
    cycle(1, 32'h10, 1, 32'h20, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h10, 0, 32'h0);
    repeat (3) idle();

    // Fill the queue; a push while full plus a hit must not grow it.
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 32'h100 + 32'(4 * i), 1, 32'h200 + 32'(i), 0, 0, 0, 0);
    cycle(1, 32'h1F0, 0, 0, 1, 32'h100, 1, 32'h200);
    cycle(1, 32'h1F4, 0, 0, 0, 0, 0, 0);
    // Mispredict on head of a full queue (target differs).
    cycle(1, 32'h1F8, 0, 0, 1, 32'h104, 1, 32'h999);
    repeat (3) idle();

    // Resolve with an empty queue -> redirect to target, sticky error.
    cycle(0, 0, 0, 0, 1, 32'h300, 1, 32'h340);
    repeat (4) idle();
    // Resolve while flushing is ignored.
    cycle(0, 0, 0, 0, 1, 32'h500, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h500, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h500, 0, 0);
    idle();

    // Fall-through wraps at the top of the address space.
    cycle(1, 32'hFFFF_FFFC, 1, 32'h8, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle();

    // Reset in the middle of a flush.
    do_reset();
    cycle(1, 32'h40, 1, 32'h80, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h40, 0, 0);
    do_reset();
    idle();

    // Randomized traffic; resolves mostly follow the model's head.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        pv   = ($urandom_range(0, 2) != 0);
        ppc  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        pt   = 1'($urandom_range(0, 1));
        ptgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        rv   = ($urandom_range(0, 1) != 0);
        rpc  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        rt   = 1'($urandom_range(0, 1));
        rtgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if (mq.size() != 0 && $urandom_range(0, 4) != 0) begin
          rpc  = mq[0].pc;
          rt   = mq[0].taken;
          rtgt = mq[0].taken ? mq[0].target : 32'($urandom);
          case ($urandom_range(0, 7))
            0: rt = ~rt;
            1: rtgt = rtgt ^ 32'h4;
            default: ;
          endcase
        end
        cycle(pv, ppc, pt, ptgt, rv, rpc, rt, rtgt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
